nibble_unpacker: RTL and testbench

//   Inverse of the concat/replicate/select datapath. Accepts a packed
//   2*NIB_W-bit word {hi,lo} over a valid/ready handshake and emits its two

---
 rtl/nibble_unpacker.sv | 159 +++++++++++++++
 tb/tb_nibble_unpacker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : nibble_unpacker
// Purpose  : Splits a packed {hi,lo} word into two nibble beats on a
//            valid/ready output stream. The per-word in_sel bit picks the
//            beat order. The block flags words whose two nibbles are equal
//            and counts fully emitted words with a wrapping counter.
// Ports    : clk        - rising-edge clock
//            rst_n      - asynchronous reset, active low
//            in_valid   - in_data/in_sel are valid
//            in_ready   - a word can be accepted this cycle
//            in_data    - packed word {hi,lo}, 2*NIB_W bits
//            in_sel     - 1: hi nibble first, 0: lo nibble first
//            out_valid  - out_data holds a nibble
//            out_ready  - downstream accepts the nibble
//            out_data   - current nibble, NIB_W bits
//            out_last   - second nibble of a word
//            out_rep    - the word's hi == lo (held on both beats)
//            word_cnt   - number of fully emitted words (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module nibble_unpacker #(
  parameter int NIB_W = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*NIB_W-1:0] in_data,
  input  logic               in_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NIB_W-1:0]   out_data,
  output logic               out_last,
  output logic               out_rep,
  output logic [CNT_W-1:0]   word_cnt
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [NIB_W-1:0]   first_q, first_d;
  logic [NIB_W-1:0]   second_q, second_d;
  logic               rep_q, rep_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               live_q, live_d;

  logic [NIB_W-1:0]   in_hi;
  logic [NIB_W-1:0]   in_lo;
  logic               accept;
  logic               beat;

  assign in_hi = in_data[2*NIB_W-1:NIB_W];
  assign in_lo = in_data[NIB_W-1:0];

  // Output decode: everything is a function of registered state, so there is
  // no combinational path from in_data/in_valid to the output stream.
  // live_q keeps in_ready low while reset is held and for the first edge
  // after release, since EMPTY alone would otherwise advertise readiness.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_rep   = 1'b0;
    case (state_q)
      EMPTY: begin
        in_ready = live_q;
      end
      FIRST: begin
        out_valid = 1'b1;
        out_data  = first_q;
        out_rep   = rep_q;
      end
      SECOND: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
        out_data  = second_q;
        out_last  = 1'b1;
        out_rep   = rep_q;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign beat     = out_valid && out_ready;
  assign word_cnt = cnt_q;

  // Next-state logic. Nibbles are stored already in emission order so the
  // output mux only needs the state, not the latched select bit.
  always_comb begin
    state_d  = state_q;
    first_d  = first_q;
    second_d = second_q;
    rep_d    = rep_q;
    cnt_d    = cnt_q;
    live_d   = 1'b1;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FIRST;
        end
      end
      FIRST: begin
        if (beat) begin
          state_d = SECOND;
        end
      end
      SECOND: begin
        if (beat) begin
          cnt_d   = cnt_q + CNT_ONE;
          // Back-to-back: a new word may be taken on the same edge the
          // last nibble leaves, giving one word every two cycles.
          state_d = accept ? FIRST : EMPTY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    if (accept) begin
      first_d  = in_sel ? in_hi : in_lo;
      second_d = in_sel ? in_lo : in_hi;
      rep_d    = (in_hi == in_lo);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      first_q  <= '0;
      second_q <= '0;
      rep_q    <= 1'b0;
      cnt_q    <= '0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      first_q  <= first_d;
      second_q <= second_d;
      rep_q    <= rep_d;
      cnt_q    <= cnt_d;
      live_q   <= live_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nibble_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_unpacker
// Purpose  : Directed self-checking bench for nibble_unpacker. A second
//            instance with a 2-bit counter shares all inputs to exercise
//            counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_unpacker;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_sel;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_last;
  logic       out_rep;
  logic [7:0] word_cnt;

  logic       in_ready2;
  logic       out_valid2;
  logic [3:0] out_data2;
  logic       out_last2;
  logic       out_rep2;
  logic [1:0] word_cnt2;

  int n_cmp;
  int n_err;

  nibble_unpacker #(.NIB_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_rep(out_rep), .word_cnt(word_cnt)
  );

  nibble_unpacker #(.NIB_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_last(out_last2), .out_rep(out_rep2), .word_cnt(word_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between clock edges, then let one edge pass so in_ready rises.
  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!in_ready && k < 10) begin
      tick();
      k++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // One complete word with out_ready high; expected beats given by hand.
  task automatic do_word(input string tag, input logic [7:0] d, input logic s,
                         input logic [3:0] e1, input logic [3:0] e2,
                         input logic erep, input logic [7:0] ecnt);
    wait_ready();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_sel    = s;
    tick();
    in_valid  = 1'b0;
    chk({tag, "_v1"},    32'(out_valid), 32'd1);
    chk({tag, "_d1"},    32'(out_data),  32'(e1));
    chk({tag, "_last1"}, 32'(out_last),  32'd0);
    chk({tag, "_rep1"},  32'(out_rep),   32'(erep));
    tick();
    chk({tag, "_d2"},    32'(out_data),  32'(e2));
    chk({tag, "_last2"}, 32'(out_last),  32'd1);
    chk({tag, "_rep2"},  32'(out_rep),   32'(erep));
    tick();
    chk({tag, "_idle"},  32'(out_valid), 32'd0);
    chk({tag, "_cnt"},   32'(word_cnt),  32'(ecnt));
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_sel    = 1'b0;
    out_ready = 1'b1;
    #12;
    // Reset state
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_out_rep",   32'(out_rep),   32'd0);
    chk("rst_word_cnt",  32'(word_cnt),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // 1: hi first
    do_word("t1_DA", 8'hDA, 1'b1, 4'hD, 4'hA, 1'b0, 8'd1);

    // 2: lo first, replication flag
    do_word("t2_69", 8'h69, 1'b0, 4'h9, 4'h6, 1'b0, 8'd2);
    do_word("t2_55", 8'h55, 1'b0, 4'h5, 4'h5, 1'b1, 8'd3);
    do_word("t2_F0", 8'hF0, 1'b0, 4'h0, 4'hF, 1'b0, 8'd4);

    // 3: backpressure, input changes ignored
    wait_ready();
    in_valid  = 1'b1;
    in_data   = 8'hC3;
    in_sel    = 1'b1;
    out_ready = 1'b0;
    tick();
    in_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_data",  32'(out_data),  32'hC);
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_last",  32'(out_last),  32'd0);
      chk("t3_hold_ready", 32'(in_ready),  32'd0);
      tick();
    end
    in_valid  = 1'b0;
    chk("t3_beat1", 32'(out_data), 32'hC);
    out_ready = 1'b1;
    tick();
    chk("t3_beat2", 32'(out_data), 32'h3);
    chk("t3_last2", 32'(out_last), 32'd1);
    tick();
    chk("t3_cnt", 32'(word_cnt), 32'd5);

    // 4: back-to-back throughput
    do_reset();
    in_valid  = 1'b1;
    in_sel    = 1'b1;
    in_data   = 8'h3C;
    out_ready = 1'b1;
    tick();
    chk("t4_b0", 32'(out_data), 32'h3);
    tick();
    chk("t4_b1", 32'(out_data), 32'hC);
    chk("t4_rdy_second", 32'(in_ready), 32'd1);
    in_data = 8'hA5;
    tick();
    chk("t4_b2", 32'(out_data), 32'hA);
    chk("t4_b2_valid", 32'(out_valid), 32'd1);
    chk("t4_b2_last", 32'(out_last), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("t4_b3", 32'(out_data), 32'h5);
    chk("t4_b3_last", 32'(out_last), 32'd1);
    tick();
    chk("t4_cnt", 32'(word_cnt), 32'd2);
    chk("t4_idle", 32'(out_valid), 32'd0);

    // 5: 2-bit counter wrap on the second instance
    do_reset();
    do_word("t5_w1", 8'h11, 1'b1, 4'h1, 4'h1, 1'b1, 8'd1);
    chk("t5_cnt2_1", 32'(word_cnt2), 32'd1);
    do_word("t5_w2", 8'h24, 1'b1, 4'h2, 4'h4, 1'b0, 8'd2);
    chk("t5_cnt2_2", 32'(word_cnt2), 32'd2);
    do_word("t5_w3", 8'h8B, 1'b0, 4'hB, 4'h8, 1'b0, 8'd3);
    chk("t5_cnt2_3", 32'(word_cnt2), 32'd3);
    do_word("t5_w4", 8'hE7, 1'b1, 4'hE, 4'h7, 1'b0, 8'd4);
    chk("t5_cnt2_0", 32'(word_cnt2), 32'd0);

    // 6: asynchronous reset mid-word
    wait_ready();
    in_valid = 1'b1;
    in_data  = 8'h7E;
    in_sel   = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t6_first", 32'(out_data), 32'h7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_data",  32'(out_data),  32'd0);
    chk("t6_rst_last",  32'(out_last),  32'd0);
    chk("t6_rst_rep",   32'(out_rep),   32'd0);
    chk("t6_rst_ready", 32'(in_ready),  32'd0);
    chk("t6_rst_cnt",   32'(word_cnt),  32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    do_word("t6_12", 8'h12, 1'b1, 4'h1, 4'h2, 1'b0, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
